zynet_cfg_loader: RTL

Hardware configuration sequencer for the zyNet accelerator. It walks a weight/bias ROM and drives zyNet's AXI4-Lite slave as a single-outstanding write master. It performs the soft-reset clear, then every layer-select, neuron-select, weight and bias register write. It replaces software/testbench configuration, so the network is loaded autonomously after power-up or on demand.

---
 rtl/zynet_cfg_loader_if.sv | 25 ++
 rtl/zynet_cfg_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/zynet_cfg_loader_if.sv
// AXI4-Lite write-only channel bundle between the config loader (master)
// and the zyNet register slave.
interface zynet_cfg_loader_if;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/zynet_cfg_loader.sv
// Autonomous zyNet configuration sequencer: walks the weight/bias ROM and
// issues soft-reset, layer, neuron, weight and bias writes over AXI4-Lite.
module zynet_cfg_loader #(
   parameter int                       NUM_LAYERS    = 4,
   parameter int                       DATA_WIDTH    = 16,
   parameter int                       ROM_AW        = 16,
   parameter logic [8*NUM_LAYERS-1:0]  LAYER_NEURONS = {8'd10, 8'd10, 8'd30, 8'd30},
   parameter logic [10*NUM_LAYERS-1:0] LAYER_WEIGHTS = {10'd10, 10'd30, 10'd30, 10'd784}
) (
   input  logic                  s_axi_aclk,
   input  logic                  s_axi_aresetn,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ROM_AW-1:0]     rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   zynet_cfg_loader_if.master    m_axi
);

   localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_WRITE, S_RESP, S_DONE} state_t;
   typedef enum logic [2:0] {P_SRST, P_LAYER, P_NEURON, P_WEIGHT, P_BIAS} phase_t;

   state_t                state_q, state_d;
   phase_t                phase_q, phase_d;
   logic [LW-1:0]         layer_q, layer_d;
   logic [7:0]            neuron_q, neuron_d;
   logic [9:0]            weight_q, weight_d;
   logic [ROM_AW-1:0]     rom_addr_q, rom_addr_d;
   logic [DATA_WIDTH-1:0] rom_word_q, rom_word_d;
   logic                  err_q, err_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic                  launch;
   logic                  aw_hs, w_hs;
   logic [31:0]           awaddr_mux, wdata_mux;

   logic [7:0] neurons_cfg [NUM_LAYERS];
   logic [9:0] weights_cfg [NUM_LAYERS];

   for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_cfg
      assign neurons_cfg[gi] = LAYER_NEURONS[8*gi +: 8];
      assign weights_cfg[gi] = LAYER_WEIGHTS[10*gi +: 10];
   end

   assign aw_hs = awvalid_q & m_axi.awready;
   assign w_hs  = wvalid_q  & m_axi.wready;

   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         state_q    <= S_IDLE;
         phase_q    <= P_SRST;
         layer_q    <= '0;
         neuron_q   <= '0;
         weight_q   <= '0;
         rom_addr_q <= '0;
         rom_word_q <= '0;
         err_q      <= 1'b0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         layer_q    <= layer_d;
         neuron_q   <= neuron_d;
         weight_q   <= weight_d;
         rom_addr_q <= rom_addr_d;
         rom_word_q <= rom_word_d;
         err_q      <= err_d;
         awvalid_q  <= awvalid_d;
         wvalid_q   <= wvalid_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      layer_d    = layer_q;
      neuron_d   = neuron_q;
      weight_d   = weight_q;
      rom_addr_d = rom_addr_q;
      rom_word_d = rom_word_q;
      err_d      = err_q;
      awvalid_d  = awvalid_q;
      wvalid_d   = wvalid_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      launch     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d      = 1'b0;
               layer_d    = '0;
               neuron_d   = '0;
               weight_d   = '0;
               rom_addr_d = '0;
               phase_d    = P_SRST;
               launch     = 1'b1;
            end
         end
         S_FETCH: state_d = S_LATCH;
         S_LATCH: begin
            rom_word_d = rom_data;
            launch     = 1'b1;
         end
         S_WRITE: begin
            // AW and W retire independently; leave only once both have landed
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_RESP;
         end
         S_RESP: begin
            if (m_axi.bvalid) begin
               err_d = err_q | (m_axi.bresp != 2'b00);
               unique case (phase_q)
                  P_SRST: begin
                     phase_d = P_LAYER;
                     launch  = 1'b1;
                  end
                  P_LAYER: begin
                     phase_d  = P_NEURON;
                     neuron_d = '0;
                     launch   = 1'b1;
                  end
                  P_NEURON: begin
                     phase_d  = P_WEIGHT;
                     weight_d = '0;
                     state_d  = S_FETCH;
                  end
                  P_WEIGHT: begin
                     rom_addr_d = rom_addr_q + ROM_AW'(1);
                     state_d    = S_FETCH;
                     if (weight_q == weights_cfg[layer_q] - 10'd1) phase_d = P_BIAS;
                     else weight_d = weight_q + 10'd1;
                  end
                  P_BIAS: begin
                     rom_addr_d = rom_addr_q + ROM_AW'(1);
                     if (neuron_q != neurons_cfg[layer_q] - 8'd1) begin
                        neuron_d = neuron_q + 8'd1;
                        phase_d  = P_NEURON;
                        launch   = 1'b1;
                     end else if (layer_q != LW'(NUM_LAYERS - 1)) begin
                        layer_d = layer_q + LW'(1);
                        phase_d = P_LAYER;
                        launch  = 1'b1;
                     end else begin
                        state_d = S_DONE;
                     end
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (launch) begin
         state_d   = S_WRITE;
         awvalid_d = 1'b1;
         wvalid_d  = 1'b1;
         aw_done_d = 1'b0;
         w_done_d  = 1'b0;
      end
   end

   // Address and data derive from registers that only move in RESP, so both
   // stay stable for the whole time the valids are up.
   always_comb begin
      awaddr_mux = 32'd0;
      wdata_mux  = 32'd0;
      case (phase_q)
         P_SRST:   begin awaddr_mux = 32'd28; wdata_mux = 32'd0;                   end
         P_LAYER:  begin awaddr_mux = 32'd12; wdata_mux = 32'(layer_q) + 32'd1;    end
         P_NEURON: begin awaddr_mux = 32'd16; wdata_mux = 32'(neuron_q);           end
         P_WEIGHT: begin awaddr_mux = 32'd0;  wdata_mux = 32'(rom_word_q);         end
         P_BIAS:   begin awaddr_mux = 32'd4;  wdata_mux = 32'(rom_word_q);         end
         default:  begin awaddr_mux = 32'd0;  wdata_mux = 32'd0;                   end
      endcase
   end

   assign m_axi.awaddr  = awaddr_mux;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.awvalid = awvalid_q;
   assign m_axi.wdata   = wdata_mux;
   assign m_axi.wstrb   = 4'hF;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.bready  = (state_q == S_RESP);

   assign busy     = (state_q == S_FETCH) || (state_q == S_LATCH) ||
                     (state_q == S_WRITE) || (state_q == S_RESP);
   assign done     = (state_q == S_DONE);
   assign err      = err_q;
   assign rom_addr = rom_addr_q;

endmodule
